// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard/bubble FSM states, the zero bubble
// and the control-bundle field layout used by the control unit and ID/EX register.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } hb_state_t;

   localparam int CTRL_W_DEF = 8;
   localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = 8'h00;

   // Bit positions inside the packed control bundle
   localparam int CF_BRANCH    = 7;
   localparam int CF_MEMREAD   = 6;
   localparam int CF_MEMTOREG  = 5;
   localparam int CF_ALUOP_MSB = 4;
   localparam int CF_ALUOP_LSB = 3;
   localparam int CF_MEMWRITE  = 2;
   localparam int CF_ALUSRC    = 1;
   localparam int CF_REGWRITE  = 0;

endpackage

// File: rtl/hazard_bubble_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_r;

   // count register: clear wins, then saturating increment
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (inc && (cnt_r != {W{1'b1}})) begin
         cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign count = cnt_r;

endmodule

// File: rtl/hazard_bubble_ctrl.sv
// ID/EX control stage: load-use stall and branch-flush sequencing, replacing the
// control bundle with a zero bubble and counting the bubbles injected.
module hazard_bubble_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CTRL_W       = 8,
   parameter int REG_AW       = 5,
   parameter int LOAD_STALL   = 1,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_memread,
   input  logic              branch_taken,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic [15:0]       bubble_cnt
);

   // rem holds "extra cycles after this one", hence the -2 on entry
   localparam logic [3:0] STALL_REM = (LOAD_STALL > 1)   ? 4'(LOAD_STALL - 2)   : 4'd0;
   localparam logic [3:0] FLUSH_REM = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

   hb_state_t         state_r;
   logic [3:0]        rem_r;
   logic [CTRL_W-1:0] ctrl_r;
   logic              haz_s;
   logic              bubble_s;

   assign haz_s = ex_memread && (ex_rd != {REG_AW{1'b0}}) &&
                  ((id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd)));

   // same-cycle enables and bubble select; branch overrides any state
   always_comb begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      bubble_s   = 1'b0;
      if (!rst_n) begin
         bubble_s = 1'b0;
      end else if (branch_taken) begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         ifid_flush = 1'b1;
         bubble_s   = 1'b1;
      end else begin
         case (state_r)
            RUN: begin
               if (haz_s) begin
                  bubble_s = 1'b1;
               end else begin
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
               end
            end
            STALL: bubble_s = 1'b1;
            FLUSH: begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
               bubble_s   = 1'b1;
            end
            default: bubble_s = 1'b1;
         endcase
      end
   end

   // state, remaining-cycle counter and ID/EX control register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= RUN;
         rem_r   <= 4'd0;
         ctrl_r  <= CTRL_W'(CTRL_BUBBLE);
      end else begin
         ctrl_r <= bubble_s ? CTRL_W'(CTRL_BUBBLE) : ctrl_in;
         if (branch_taken) begin
            state_r <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            rem_r   <= FLUSH_REM;
         end else begin
            case (state_r)
               RUN: begin
                  if (haz_s && (LOAD_STALL > 1)) begin
                     state_r <= STALL;
                     rem_r   <= STALL_REM;
                  end else begin
                     state_r <= RUN;
                     rem_r   <= 4'd0;
                  end
               end
               STALL, FLUSH: begin
                  if (rem_r == 4'd0) begin
                     state_r <= RUN;
                  end else begin
                     rem_r <= rem_r - 4'd1;
                  end
               end
               default: begin
                  state_r <= RUN;
                  rem_r   <= 4'd0;
               end
            endcase
         end
      end
   end

   assign ctrl_out = ctrl_r;

   sat_counter #(.W(16)) u_cnt (
      .clk   (clk),
      .inc   (bubble_s),
      .clr   (!rst_n),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Self-checking bench: three configurations driven in lockstep and compared each
// cycle against a cycle-count model of stall/flush windows.
module tb_hazard_bubble_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] ctrl_in;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_memread, branch_taken;

   logic [7:0]  co [3];
   logic        pw [3];
   logic        iw [3];
   logic        fl [3];
   logic [15:0] bc [3];

   int vectors = 0;
   int miscompares = 0;

   // model configuration and state per instance
   int          ls [3] = '{1, 3, 3};
   int          fc [3] = '{1, 1, 4};
   int          stall_left [3];
   int          flush_left [3];
   logic [7:0]  m_ctrl [3];
   int          m_cnt [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   hazard_bubble_ctrl #(.LOAD_STALL(1), .FLUSH_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .branch_taken(branch_taken), .ctrl_out(co[0]),
      .pc_write(pw[0]), .ifid_write(iw[0]), .ifid_flush(fl[0]), .bubble_cnt(bc[0]));

   hazard_bubble_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .branch_taken(branch_taken), .ctrl_out(co[1]),
      .pc_write(pw[1]), .ifid_write(iw[1]), .ifid_flush(fl[1]), .bubble_cnt(bc[1]));

   hazard_bubble_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .branch_taken(branch_taken), .ctrl_out(co[2]),
      .pc_write(pw[2]), .ifid_write(iw[2]), .ifid_flush(fl[2]), .bubble_cnt(bc[2]));

   task automatic check(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s inst%0d: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   // one clock: drive, check same-cycle enables, advance model, check registered outputs
   task automatic step(input logic r, input logic b, input logic mr, input logic [4:0] rd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                       input logic u2, input logic [7:0] c);
      logic h, epw, eiw, efl, bub;
      rst_n = r; branch_taken = b; ex_memread = mr; ex_rd = rd;
      id_rs1 = a1; id_rs2 = a2; id_rs1_used = u1; id_rs2_used = u2; ctrl_in = c;
      #2;
      vectors++;
      h = mr && (rd != 5'd0) && ((u1 && (a1 == rd)) || (u2 && (a2 == rd)));
      for (int k = 0; k < 3; k++) begin
         bub = 1'b1;
         if (!r) begin
            epw = 1'b0; eiw = 1'b0; efl = 1'b0; bub = 1'b0;
            stall_left[k] = 0; flush_left[k] = 0; m_cnt[k] = 0;
         end else if (b) begin
            epw = 1'b1; eiw = 1'b1; efl = 1'b1;
            stall_left[k] = 0; flush_left[k] = fc[k] - 1;
         end else if (flush_left[k] > 0) begin
            epw = 1'b1; eiw = 1'b1; efl = 1'b1;
            flush_left[k]--;
         end else if (stall_left[k] > 0) begin
            epw = 1'b0; eiw = 1'b0; efl = 1'b0;
            stall_left[k]--;
         end else if (h) begin
            epw = 1'b0; eiw = 1'b0; efl = 1'b0;
            stall_left[k] = ls[k] - 1;
         end else begin
            epw = 1'b1; eiw = 1'b1; efl = 1'b0; bub = 1'b0;
         end
         m_ctrl[k] = (bub || !r) ? 8'h00 : c;
         if (bub && m_cnt[k] < 65535) m_cnt[k]++;
         check("pc_write",   k, {15'd0, pw[k]}, {15'd0, epw});
         check("ifid_write", k, {15'd0, iw[k]}, {15'd0, eiw});
         check("ifid_flush", k, {15'd0, fl[k]}, {15'd0, efl});
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("ctrl_out",   k, {8'd0, co[k]}, {8'd0, m_ctrl[k]});
         check("bubble_cnt", k, bc[k], 16'(m_cnt[k]));
      end
   endtask

   initial begin
      rst_n = 1'b0; branch_taken = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; ctrl_in = 8'h00;
      for (int k = 0; k < 3; k++) begin
         stall_left[k] = 0; flush_left[k] = 0; m_ctrl[k] = 8'h00; m_cnt[k] = 0;
      end
      @(posedge clk); #1;
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h3C);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h3C);
      // pass-through
      step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 8'hA5);
      // load-use on rs2, held until each stall window ends
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 8'h5A);
      step(1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 8'h5A);
      step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 8'h11);
      // x0 destination and unused operand never stall
      step(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 8'h22);
      step(1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b1, 8'h33);
      // branch in second stall cycle
      step(1'b1, 1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 8'h44);
      step(1'b1, 1'b1, 1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 8'h44);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 8'h55);
      // simultaneous branch and hazard, then reset mid-flush
      step(1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 8'h66);
      step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 8'h77);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 8'h88);
      step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 8'h99);
      // saturation: preload 16'hFFFE then three branch bubbles
      force dut_a.u_cnt.cnt_r = 16'hFFFE;
      #1;
      release dut_a.u_cnt.cnt_r;
      m_cnt[0] = 65534;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 8'hF0);
      step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 8'h0F);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 8'h0F);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
